// File: rtl/bram_responder_pkg.sv
// Shared encodings and lane helpers for the block-RAM responder.
package bram_responder_pkg;

  localparam logic [1:0] DW_BYTE = 2'b00;
  localparam logic [1:0] DW_HALF = 2'b01;
  localparam logic [1:0] DW_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP,
    S_HOLD
  } state_t;

  // Little-endian lane mask; width 2'b11 behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] dw, input logic [1:0] off);
    case (dw)
      DW_BYTE: return 4'b0001 << off;
      DW_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] dw, input logic [1:0] off);
    case (dw)
      DW_BYTE: return 1'b0;
      DW_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bram_responder_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
module bram_be
  import bram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (!we) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_responder.sv
// Block-RAM target for the enable/ready memory handshake, with programmable wait states.
module bram_responder
  import bram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] addr,
  input  logic        write,
  input  logic [31:0] write_data,
  input  logic [1:0]  data_width,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_nx;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic [1:0]    off, dw;
  logic          wr;
  logic [31:0]   wd, ram_wd, ram_q, rd_shift, rd_hold;
  logic          addr_unused;

  assign addr_unused = ^addr[23:AW+2];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (enable) state_nx = (LATENCY > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd1) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_HOLD;
      S_HOLD:   if (!enable) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    case (dw)
      DW_BYTE: ram_wd = {4{wd[7:0]}};
      DW_HALF: ram_wd = {2{wd[15:0]}};
      default: ram_wd = wd;
    endcase
  end

  always_comb begin
    case (dw)
      DW_BYTE: rd_shift = {24'b0, ram_q[{off, 3'b000} +: 8]};
      DW_HALF: rd_shift = {16'b0, ram_q[{off[1], 4'b0000} +: 16]};
      default: rd_shift = ram_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      off     <= '0;
      dw      <= DW_WORD;
      wr      <= 1'b0;
      wd      <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rd_hold <= '0;
    end else begin
      state <= state_nx;
      ready <= (state == S_ACCESS);
      err   <= (state == S_ACCESS) && misaligned(dw, off);
      if (state == S_IDLE && enable) begin
        idx <= addr[AW+1:2];
        off <= addr[1:0];
        dw  <= data_width;
        wr  <= write;
        wd  <= write_data;
        cnt <= 4'(LATENCY);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_RESP && !wr) rd_hold <= rd_shift;
    end
  end

  // RAM output register is live only in RESP; afterwards the captured copy holds.
  assign read_data = (state == S_RESP && !wr) ? rd_shift : rd_hold;

  bram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (state == S_ACCESS),
    .we    (wr),
    .be    (byte_en(dw, off)),
    .addr  (idx),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_bram_responder.sv
// Directed checks of the responder at latencies 0, 2 and 15.
module tb_bram_responder;
  import bram_responder_pkg::*;

  logic        clk, rst;
  logic        en [3];
  logic [23:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [1:0]  dw;
  logic [31:0] rdata [3];
  logic        rdy [3];
  logic        erro [3];

  int total = 0;
  int bad   = 0;

  bram_responder #(.DEPTH_WORDS(4096), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .enable(en[0]), .addr(addr), .write(write), .write_data(wdata),
    .data_width(dw), .read_data(rdata[0]), .ready(rdy[0]), .err(erro[0]));
  bram_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .enable(en[1]), .addr(addr), .write(write), .write_data(wdata),
    .data_width(dw), .read_data(rdata[1]), .ready(rdy[1]), .err(erro[1]));
  bram_responder #(.DEPTH_WORDS(4096), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .enable(en[2]), .addr(addr), .write(write), .write_data(wdata),
    .data_width(dw), .read_data(rdata[2]), .ready(rdy[2]), .err(erro[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // cyc is the cycle number (edge 0 samples the request) in which ready is seen.
  task automatic req(input int s, input logic w, input logic [23:0] a, input logic [31:0] d,
                     input logic [1:0] wdt, input int drop_at, input int hold,
                     output int cyc, output int npulse, output logic [31:0] rd, output logic er);
    cyc = -1; npulse = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    addr = a; write = w; wdata = d; dw = wdt; en[s] = 1'b1;
    for (int k = 0; k < 40 && cyc < 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == drop_at) en[s] = 1'b0;
      if (rdy[s]) begin cyc = k + 1; npulse++; rd = rdata[s]; er = erro[s]; end
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      if (rdy[s]) npulse++;
    end
    en[s] = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (rdy[s]) npulse++;
    end
  endtask

  int          cyc, np;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1; en[0] = 0; en[1] = 0; en[2] = 0;
    addr = '0; write = 0; wdata = '0; dw = DW_WORD;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy[1]), 32'd0);
    chk("rst_err", 32'(erro[1]), 32'd0);
    chk("rst_rdata", rdata[1], 32'h0);
    rst = 1'b0;

    req(1, 1, 24'h000010, 32'hDEADBEEF, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("wr_word_cyc", 32'(cyc), 32'd4);
    chk("wr_word_err", 32'(er), 32'd0);
    req(1, 0, 24'h000010, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("rd_word_cyc", 32'(cyc), 32'd4);
    chk("rd_word_data", rd, 32'hDEADBEEF);
    chk("rd_hold_data", rdata[1], 32'hDEADBEEF);

    // Asynchronous reset between edges clears outputs at once.
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_ready", 32'(rdy[1]), 32'd0);
    chk("mid_rst_err", 32'(erro[1]), 32'd0);
    chk("mid_rst_rdata", rdata[1], 32'h0);
    @(negedge clk); rst = 1'b0;
    np = 0;
    repeat (10) begin @(negedge clk); if (rdy[1]) np++; end
    chk("idle_no_ready", 32'(np), 32'd0);

    req(1, 1, 24'h000011, 32'h000000AA, DW_BYTE, -1, 0, cyc, np, rd, er);
    chk("wr_byte_cyc", 32'(cyc), 32'd4);
    req(1, 0, 24'h000010, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("merge_word", rd, 32'hDEADAAEF);
    req(1, 0, 24'h000012, 32'h0, DW_HALF, -1, 0, cyc, np, rd, er);
    chk("rd_half", rd, 32'h0000DEAD);
    chk("rd_half_err", 32'(er), 32'd0);
    req(1, 0, 24'h000013, 32'h0, DW_BYTE, -1, 0, cyc, np, rd, er);
    chk("rd_byte", rd, 32'h000000DE);

    req(1, 0, 24'h000013, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("mis_word_data", rd, 32'hDEADAAEF);
    chk("mis_word_err", 32'(er), 32'd1);
    req(1, 0, 24'h000011, 32'h0, DW_HALF, -1, 0, cyc, np, rd, er);
    chk("mis_half_data", rd, 32'h0000AAEF);
    chk("mis_half_err", 32'(er), 32'd1);
    req(1, 0, 24'h004010, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("alias_data", rd, 32'hDEADAAEF);
    chk("alias_err", 32'(er), 32'd0);

    // Lane replication for half and byte writes into one word.
    req(1, 1, 24'h000014, 32'hFFFFFFFF, DW_WORD, -1, 0, cyc, np, rd, er);
    req(1, 1, 24'h000016, 32'h12345566, DW_HALF, -1, 0, cyc, np, rd, er);
    req(1, 1, 24'h000014, 32'h98765477, DW_BYTE, -1, 0, cyc, np, rd, er);
    req(1, 0, 24'h000014, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("lane_mix", rd, 32'h5566FF77);

    req(0, 1, 24'h000000, 32'h11223344, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("l0_wr_cyc", 32'(cyc), 32'd2);
    req(0, 0, 24'h000000, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("l0_rd_cyc", 32'(cyc), 32'd2);
    chk("l0_rd_data", rd, 32'h11223344);
    req(2, 1, 24'h000008, 32'hCAFEF00D, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("l15_wr_cyc", 32'(cyc), 32'd17);
    req(2, 0, 24'h000008, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("l15_rd_cyc", 32'(cyc), 32'd17);
    chk("l15_rd_data", rd, 32'hCAFEF00D);

    req(1, 0, 24'h000010, 32'h0, DW_WORD, -1, 5, cyc, np, rd, er);
    chk("hold_pulses", 32'(np), 32'd1);
    req(1, 0, 24'h000010, 32'h0, DW_WORD, 0, 0, cyc, np, rd, er);
    chk("drop_cyc", 32'(cyc), 32'd4);
    chk("drop_pulses", 32'(np), 32'd1);
    chk("drop_data", rd, 32'hDEADAAEF);

    // Reset during WAIT must abandon the write.
    req(1, 1, 24'h000020, 32'h00000000, DW_WORD, -1, 0, cyc, np, rd, er);
    @(negedge clk);
    addr = 24'h000020; write = 1'b1; wdata = 32'h12345678; dw = DW_WORD; en[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; en[1] = 1'b0;
    np = 0;
    repeat (6) begin @(negedge clk); if (rdy[1]) np++; end
    rst = 1'b0;
    chk("abort_no_ready", 32'(np), 32'd0);
    req(1, 0, 24'h000020, 32'h0, DW_WORD, -1, 0, cyc, np, rd, er);
    chk("abort_cyc", 32'(cyc), 32'd4);
    chk("abort_data", rd, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
